// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side consumer for an async FIFO, living entirely in the rclk domain.
//   After a start pulse it pops BURST_LENGTH words. It waits READ_PERIOD idle
//   cycles after each pop and stalls while the FIFO is empty. Every popped word
//   is compared against an incrementing pattern that begins at seed.
//
// Ports
//   rclk, rrst_n        read clock, asynchronous active-low reset
//   start, abort        1-cycle control pulses (abort has priority)
//   seed                first expected word, captured on an accepted start
//   rempty, rdata       FIFO status and head-of-queue data
//   rinc                FIFO pop strobe
//   out_data, out_valid registered copy of the popped word, valid for 1 cycle
//   busy, done          burst in progress / burst completed
//   rd_count, err_count words popped / mismatches (saturating) in this burst
//   err_flag            sticky mismatch flag, cleared on start
//   state_dbg           current FSM state, for observation only
//
// Pop handshake: the FIFO offers a word whenever rempty=0 (rdata is valid).
// rinc is the matching "ready". A word transfers on a rising rclk edge when
// rinc=1, and rinc is only ever 1 while rempty=0.
module fifo_burst_reader #(
    parameter int DATASIZE     = 9,
    parameter int BURST_LENGTH = 1024,
    parameter int READ_PERIOD  = 1,
    parameter int CNTW         = 11
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DATASIZE-1:0] seed,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_valid,
    output logic                busy,
    output logic                done,
    output logic [CNTW-1:0]     rd_count,
    output logic [CNTW-1:0]     err_count,
    output logic                err_flag,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The gap counter only has to reach READ_PERIOD-1.
    localparam int GW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
    localparam logic [GW-1:0]       GAP_LAST  = GW'((READ_PERIOD > 0) ? READ_PERIOD - 1 : 0);
    localparam logic [CNTW-1:0]     LAST_WORD = CNTW'(BURST_LENGTH - 1);
    localparam logic [CNTW-1:0]     ERR_MAX   = '1;
    localparam logic [CNTW-1:0]     ONE_C     = 1;
    localparam logic [DATASIZE-1:0] ONE_D     = 1;
    localparam logic [GW-1:0]       ONE_G     = 1;
    localparam bit                  HAS_GAP   = (READ_PERIOD > 0);

    state_t              state, state_nxt;
    logic [DATASIZE-1:0] expected;
    logic [GW-1:0]       gap_cnt;
    logic                pop;
    logic                start_ok;
    logic                last_pop;
    logic                gap_end;

    // A pop needs READ, a non-empty FIFO, and no abort in this same cycle.
    assign pop      = (state == S_READ) && !rempty && !abort;
    assign start_ok = start && !abort && ((state == S_IDLE) || (state == S_DONE));
    assign last_pop = pop && (rd_count == LAST_WORD);
    assign gap_end  = (state == S_GAP) && (gap_cnt == GAP_LAST);

    assign rinc      = pop;
    assign busy      = (state == S_READ) || (state == S_GAP);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) state_nxt = S_READ;
            end
            S_READ: begin
                if (pop) begin
                    if (last_pop)     state_nxt = S_DONE;
                    else if (HAS_GAP) state_nxt = S_GAP;
                    else              state_nxt = S_READ;
                end
            end
            S_GAP: begin
                if (gap_end) state_nxt = S_READ;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            rd_count  <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
            expected  <= '0;
            gap_cnt   <= '0;
        end else begin
            out_valid <= pop;
            if (start_ok) begin
                expected  <= seed;
                rd_count  <= '0;
                err_count <= '0;
                err_flag  <= 1'b0;
            end
            if (pop) begin
                out_data <= rdata;
                rd_count <= rd_count + ONE_C;
                expected <= expected + ONE_D;
                if (rdata != expected) begin
                    err_flag <= 1'b1;
                    if (err_count != ERR_MAX) err_count <= err_count + ONE_C;
                end
            end
            // Restart the gap count on every pop so each gap lasts READ_PERIOD cycles.
            if (pop) begin
                gap_cnt <= '0;
            end else if ((state == S_GAP) && !gap_end) begin
                gap_cnt <= gap_cnt + ONE_G;
            end
        end
    end

endmodule
